// File: rtl/nco_pkg.sv
// Shared constants and types for the NCO phase accumulator and its dither LFSR.
package nco_pkg;

  localparam int unsigned PHASE_W  = 32;
  localparam int unsigned DITHER_W = 16;

  // Taps 16,14,13,11 expressed as a mask for a right-shifting Fibonacci register.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    APPLY     = 2'd1,
    WAIT_WRAP = 2'd2
  } nco_state_e;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/nco_lfsr16.sv
// 16-bit Fibonacci LFSR used as truncation dither; advances only when enabled.
module nco_lfsr16
  import nco_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr16_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/nco_phase_accumulator.sv
// 32-bit NCO phase accumulator with immediate / wrap-synchronous reconfiguration.
// Optional LSB dither ahead of truncation is enabled by defining PHASE_DITHER_EN.
module nco_phase_accumulator
  import nco_pkg::*;
#(
  parameter int unsigned PHASE_W  = nco_pkg::PHASE_W,
  parameter int unsigned DITHER_W = nco_pkg::DITHER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [PHASE_W-1:0] cfg_offset,
  input  logic               cfg_sync,
  output logic [PHASE_W-1:0] phase_out,
  output logic               wrap
);

  localparam int unsigned PAD_W = PHASE_W - DITHER_W;

  nco_state_e state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fcw_act_q, fcw_act_d;
  logic [PHASE_W-1:0] off_act_q, off_act_d;
  logic [PHASE_W-1:0] fcw_sh_q, fcw_sh_d;
  logic [PHASE_W-1:0] off_sh_q, off_sh_d;
  logic               sync_sh_q, sync_sh_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   sum_s;
  logic               carry_s;
  logic               load_s;
  logic [DITHER_W-1:0] dither_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, fcw_act_q};
  assign carry_s = en & ~clr & sum_s[PHASE_W];

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_s;

  nco_lfsr16 u_lfsr (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .state_o (lfsr_s)
  );

  assign dither_s = lfsr_s[DITHER_W-1:0];
`else
  assign dither_s = {DITHER_W{1'b0}};
`endif

  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    fcw_sh_d  = fcw_sh_q;
    off_sh_d  = off_sh_q;
    sync_sh_d = sync_sh_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          fcw_sh_d  = cfg_fcw;
          off_sh_d  = cfg_offset;
          sync_sh_d = cfg_sync;
          state_d   = cfg_sync ? WAIT_WRAP : APPLY;
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        load_s  = 1'b1;
        state_d = IDLE;
      end
      WAIT_WRAP: begin
        // A clear counts as a wrap so a frozen (FCW = 0) accumulator can still reconfigure.
        if (clr || carry_s || !sync_sh_q) begin
          load_s  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_WRAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    fcw_act_d = fcw_act_q;
    off_act_d = off_act_q;
    if (load_s) begin
      fcw_act_d = fcw_sh_q;
      off_act_d = off_sh_q;
    end else begin
      fcw_act_d = fcw_act_q;
      off_act_d = off_act_q;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (clr) begin
      acc_d  = {PHASE_W{1'b0}};
      wrap_d = 1'b0;
    end else if (en) begin
      acc_d  = sum_s[PHASE_W-1:0];
      wrap_d = sum_s[PHASE_W];
    end else begin
      acc_d  = acc_q;
      wrap_d = 1'b0;
    end
  end

  assign phase_d = acc_q + off_act_q + {{PAD_W{1'b0}}, dither_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= {PHASE_W{1'b0}};
      fcw_act_q <= {PHASE_W{1'b0}};
      off_act_q <= {PHASE_W{1'b0}};
      fcw_sh_q  <= {PHASE_W{1'b0}};
      off_sh_q  <= {PHASE_W{1'b0}};
      sync_sh_q <= 1'b0;
      phase_q   <= {PHASE_W{1'b0}};
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fcw_act_q <= fcw_act_d;
      off_act_q <= off_act_d;
      fcw_sh_q  <= fcw_sh_d;
      off_sh_q  <= off_sh_d;
      sync_sh_q <= sync_sh_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign phase_out = phase_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Self-checking bench for nco_phase_accumulator: directed vector table, hand-written
// reconfiguration corner cases, then randomized traffic against a reference model.
module tb_nco_phase_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, clr, cfg_valid, cfg_sync;
  logic        cfg_ready, wrap;
  logic [31:0] cfg_fcw, cfg_offset, phase_out;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  nco_phase_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_fcw    (cfg_fcw),
    .cfg_offset (cfg_offset),
    .cfg_sync   (cfg_sync),
    .phase_out  (phase_out),
    .wrap       (wrap)
  );

  typedef struct {
    logic        en, clr, v, sync;
    logic [31:0] fcw, off;
    logic [31:0] e_phase;
    logic        e_wrap, e_ready;
  } vec_t;

  vec_t tbl[$];

  // Reference model: accumulator, active settings and at most one pending request.
  bit [31:0] m_acc, m_fcw, m_off, m_phase;
  bit        m_wrap;
  bit        p_valid, p_sync;
  bit [31:0] p_fcw, p_off;

  function automatic void model_reset();
    m_acc = 0; m_fcw = 0; m_off = 0; m_phase = 0; m_wrap = 0;
    p_valid = 0; p_sync = 0; p_fcw = 0; p_off = 0;
  endfunction

  function automatic void model_step();
    longint unsigned s;
    bit carry, load;
    s       = 64'(m_acc) + 64'(m_fcw);
    carry   = en && !clr && (s >= 64'h1_0000_0000);
    m_phase = m_acc + m_off;
    m_wrap  = carry;
    load    = p_valid && (!p_sync || clr || carry);
    if (clr) m_acc = 32'h0;
    else if (en) m_acc = s[31:0];
    if (load) begin
      m_fcw = p_fcw; m_off = p_off; p_valid = 0;
    end else if (cfg_valid && !p_valid) begin
      p_valid = 1; p_sync = cfg_sync; p_fcw = cfg_fcw; p_off = cfg_offset;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic e, input logic c, input logic v, input logic sy,
                       input logic [31:0] f, input logic [31:0] o);
    en = e; clr = c; cfg_valid = v; cfg_sync = sy; cfg_fcw = f; cfg_offset = o;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic e, input logic c, input logic v, input logic sy,
                     input logic [31:0] f, input logic [31:0] o,
                     input logic [31:0] ph, input logic wr, input logic rdy);
    vec_t r;
    r.en = e; r.clr = c; r.v = v; r.sync = sy; r.fcw = f; r.off = o;
    r.e_phase = ph; r.e_wrap = wr; r.e_ready = rdy;
    tbl.push_back(r);
  endtask

  initial begin
    // Basic count at FCW = 65536
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0001_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0002_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0003_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0004_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0005_0000, 1'b0, 1'b1);
    // Clear plus immediate load of FCW = 0x80000000, then alternating wrap
    row(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0006_0000, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h8000_0000, 1'b1, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h8000_0000, 1'b1, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    // clr with en on a would-be carry edge: no wrap pulse
    row(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 32'h8000_0000, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 1'b1);
    // Offset only: FCW = 0, offset = 327685
    row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'd327685, 32'h0, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0,         1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'd327685,    1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 32'd327685,    1'b0, 1'b1);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    #12;
    chk("reset_phase", phase_out, 32'h0);
    chk("reset_wrap", {31'h0, wrap}, 32'h0);
    chk("reset_ready", {31'h0, cfg_ready}, 32'h1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].sync, tbl[i].fcw, tbl[i].off);
      tick();
      chk($sformatf("tbl%0d_phase", i), phase_out, tbl[i].e_phase);
      chk($sformatf("tbl%0d_wrap", i), {31'h0, wrap}, {31'h0, tbl[i].e_wrap});
      chk($sformatf("tbl%0d_ready", i), {31'h0, cfg_ready}, {31'h0, tbl[i].e_ready});
    end

    // Phase-continuous update: 0x40000000 running, sync request for 0x10000000
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);         tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);         tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h0); tick();
    chk("sync_ready_low0", {31'h0, cfg_ready}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h7000_0000, 32'h55); tick();
    chk("sync_ready_low1", {31'h0, cfg_ready}, 32'h0);
    chk("sync_nowrap", {31'h0, wrap}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);         tick();
    chk("sync_wrap", {31'h0, wrap}, 32'h1);
    chk("sync_ready_back", {31'h0, cfg_ready}, 32'h1);
    tick();
    chk("sync_step0", phase_out, 32'h0000_0000);
    tick();
    chk("sync_step1", phase_out, 32'h1000_0000);
    tick();
    chk("sync_step2", phase_out, 32'h2000_0000);

    // clr while waiting for a wrap forces the load on that edge
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3000_0000, 32'h100); tick();
    chk("clrw_ready0", {31'h0, cfg_ready}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);           tick();
    chk("clrw_ready1", {31'h0, cfg_ready}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);           tick();
    chk("clrw_ready2", {31'h0, cfg_ready}, 32'h1);
    chk("clrw_phase0", phase_out, 32'h3000_0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);           tick();
    chk("clrw_phase1", phase_out, 32'h0000_0100);
    tick();
    chk("clrw_phase2", phase_out, 32'h3000_0100);

    // Reset while waiting for a wrap drops the pending request
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h5000_0000, 32'h7); tick();
    chk("rstw_ready0", {31'h0, cfg_ready}, 32'h0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rstw_ready1", {31'h0, cfg_ready}, 32'h1);
    chk("rstw_phase0", phase_out, 32'h0);
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick(); tick();
    chk("rstw_phase1", phase_out, 32'h0);
    chk("rstw_ready2", {31'h0, cfg_ready}, 32'h1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f;
      case ($urandom_range(0, 3))
        0: f = 32'h0;
        1: f = $urandom;
        2: f = 32'h4000_0000;
        3: f = $urandom_range(0, 65535) << 16;
        default: f = 32'h1;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), f, $urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      tick();
      chk($sformatf("rnd%0d_phase", i), phase_out, m_phase);
      chk($sformatf("rnd%0d_wrap", i), {31'h0, wrap}, {31'h0, m_wrap});
      chk($sformatf("rnd%0d_ready", i), {31'h0, cfg_ready}, {31'h0, !p_valid});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
